// File: rtl/dff_pipe_reg.sv
// Parametrised posedge register pipeline: DEPTH stages of WIDTH-bit data plus a valid bit,
// with global stall, flush and a registered occupancy count.
module dff_pipe_reg #(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           d_in,
  input  logic                       d_valid,
  output logic [WIDTH-1:0]           q_out,
  output logic                       q_valid,
  output logic [WIDTH*DEPTH-1:0]     tap_out,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int unsigned OccW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [OccW-1:0]  occ_q, occ_d;

  // Flush is folded into next-state; reset stays in the register process so it wins.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    occ_d   = occ_q;
    if (flush) begin
      for (int k = 0; k < int'(DEPTH); k++) begin
        data_d[k] = RESET_VAL;
      end
      valid_d = '0;
      occ_d   = '0;
    end else if (en) begin
      data_d[0]  = d_in;
      valid_d[0] = d_valid;
      for (int k = 1; k < int'(DEPTH); k++) begin
        data_d[k]  = data_q[k-1];
        valid_d[k] = valid_q[k-1];
      end
      occ_d = occ_q + OccW'(d_valid) - OccW'(valid_q[DEPTH-1]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < int'(DEPTH); k++) begin
        data_q[k] <= RESET_VAL;
      end
      valid_q <= '0;
      occ_q   <= '0;
    end else begin
      for (int k = 0; k < int'(DEPTH); k++) begin
        data_q[k] <= data_d[k];
      end
      valid_q <= valid_d;
      occ_q   <= occ_d;
    end
  end

  always_comb begin
    tap_out = '0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      tap_out[k*WIDTH +: WIDTH] = data_q[k];
    end
  end

  assign q_out     = data_q[DEPTH-1];
  assign q_valid   = valid_q[DEPTH-1];
  assign occupancy = occ_q;

endmodule

// File: tb/tb_dff_pipe_reg.sv
// Scoreboard bench for dff_pipe_reg: expected outputs queued at issue, popped by a monitor
// whenever the main instance presents a valid output after an advancing edge.
module tb_dff_pipe_reg;

  logic        clk = 1'b0;
  logic        reset = 1'b1, en = 1'b0, flush = 1'b0, d_valid = 1'b0;
  logic [7:0]  d_in = 8'h00;
  logic        d1_in = 1'b0, d1_valid = 1'b0;

  logic [7:0]  q_out, q_out_5a;
  logic        q_valid, q_valid_5a;
  logic [31:0] tap_out, tap_5a;
  logic [2:0]  occ, occ_5a;

  logic        q1_out, q1_valid, tap1;
  logic [0:0]  occ1;

  int ntotal = 0;
  int npass  = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  dff_pipe_reg #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h00)) u_dut (
    .clk(clk), .reset(reset), .en(en), .flush(flush), .d_in(d_in), .d_valid(d_valid),
    .q_out(q_out), .q_valid(q_valid), .tap_out(tap_out), .occupancy(occ)
  );

  dff_pipe_reg #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h5A)) u_dut_5a (
    .clk(clk), .reset(reset), .en(en), .flush(flush), .d_in(d_in), .d_valid(d_valid),
    .q_out(q_out_5a), .q_valid(q_valid_5a), .tap_out(tap_5a), .occupancy(occ_5a)
  );

  dff_pipe_reg #(.WIDTH(1), .DEPTH(1), .RESET_VAL(1'b0)) u_dut_d1 (
    .clk(clk), .reset(reset), .en(en), .flush(flush), .d_in(d1_in), .d_valid(d1_valid),
    .q_out(q1_out), .q_valid(q1_valid), .tap_out(tap1), .occupancy(occ1)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Inputs change on negedge; checks run 2 time units after the following posedge.
  task automatic drive(input logic r, input logic f, input logic e, input logic dv,
                       input logic [7:0] d, input logic d1, input logic d1v);
    @(negedge clk);
    reset = r; flush = f; en = e; d_valid = dv; d_in = d;
    d1_in = d1; d1_valid = d1v;
    if (r || f) exp_q.delete();
    else if (e && dv) exp_q.push_back(d);
    @(posedge clk);
    #2;
  endtask

  // Monitor: one pop per advancing edge that leaves q_valid high.
  initial begin
    logic adv;
    logic [7:0] e;
    forever begin
      @(posedge clk);
      adv = en && !reset && !flush;
      #1;
      if (adv && q_valid) begin
        if (exp_q.size() == 0) begin
          ntotal++;
          $display("FAIL sb_unexpected: got q_out %h with no expected entry", q_out);
        end else begin
          e = exp_q.pop_front();
          chk("sb_q_out", {56'h0, q_out}, {56'h0, e});
        end
      end
    end
  end

  initial begin
    logic [7:0] v [4];
    logic       m_q, m_v;

    // T1 reset
    drive(1, 0, 0, 0, 8'h00, 0, 0);
    drive(1, 0, 0, 0, 8'h00, 0, 0);
    chk("t1_q_out", {56'h0, q_out}, 64'h0);
    chk("t1_q_valid", {63'h0, q_valid}, 64'h0);
    chk("t1_occ", {61'h0, occ}, 64'h0);
    chk("t1_tap", {32'h0, tap_out}, 64'h0);
    chk("t5_tap_5a_reset", {32'h0, tap_5a}, 64'h5A5A5A5A);
    chk("t6_d1_reset", {62'h0, q1_valid, q1_out}, 64'h0);

    // T2 latency and drain
    v[0] = 8'hA1; v[1] = 8'hA2; v[2] = 8'hA3; v[3] = 8'hA4;
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, 1, v[i], 0, 0);
      chk("t2_fill_occ", {61'h0, occ}, 64'(i + 1));
      chk("t2_fill_qv", {63'h0, q_valid}, (i == 3) ? 64'h1 : 64'h0);
    end
    chk("t2_first_out", {56'h0, q_out}, 64'hA1);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, 0, 8'h00, 0, 0);
      chk("t2_drain_occ", {61'h0, occ}, 64'(3 - i));
      chk("t2_drain_qv", {63'h0, q_valid}, (i == 3) ? 64'h0 : 64'h1);
    end

    // T3 stall
    drive(0, 1, 0, 0, 8'h00, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 1, 1, v[i], 0, 0);
    chk("t3_tap_filled", {32'h0, tap_out}, 64'h00A1A2A3);
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 1, 8'hFF, 0, 0);
      chk("t3_stall_tap", {32'h0, tap_out}, 64'h00A1A2A3);
      chk("t3_stall_occ", {61'h0, occ}, 64'h3);
    end
    drive(0, 0, 1, 0, 8'h00, 0, 0);
    chk("t3_resume_q", {55'h0, q_valid, q_out}, 64'h1A1);
    chk("t3_resume_occ", {61'h0, occ}, 64'h3);
    chk("t3_resume_tap", {32'h0, tap_out}, 64'hA1A2A300);

    // T4 flush beats en
    drive(0, 1, 0, 0, 8'h00, 0, 0);
    for (int i = 0; i < 4; i++) drive(0, 0, 1, 1, 8'hC1 + 8'(i), 0, 0);
    chk("t4_full_occ", {61'h0, occ}, 64'h4);
    drive(0, 1, 1, 1, 8'hEE, 0, 0);
    chk("t4_flush_occ", {61'h0, occ}, 64'h0);
    chk("t4_flush_qv", {63'h0, q_valid}, 64'h0);
    chk("t4_flush_tap", {32'h0, tap_out}, 64'h0);
    chk("t4_flush_tap_5a", {32'h0, tap_5a}, 64'h5A5A5A5A);

    // T5 reset beats flush/en
    drive(0, 0, 1, 1, 8'hD1, 0, 0);
    drive(0, 0, 1, 1, 8'hD2, 0, 0);
    chk("t5_pre_occ", {61'h0, occ}, 64'h2);
    drive(1, 0, 1, 1, 8'h77, 0, 0);
    chk("t5_occ", {61'h0, occ}, 64'h0);
    chk("t5_q", {55'h0, q_valid, q_out}, 64'h0);
    chk("t5_tap", {32'h0, tap_out}, 64'h0);
    chk("t5_tap_5a", {32'h0, tap_5a}, 64'h5A5A5A5A);
    chk("t5_occ_5a", {61'h0, occ_5a}, 64'h0);

    // T6 DEPTH=1 WIDTH=1 against a single-DFF model
    m_q = 1'b0; m_v = 1'b0;
    for (int i = 0; i < 5; i++) begin
      logic b, bv;
      b  = (i == 1 || i == 3) ? 1'b0 : 1'b1;
      bv = (i < 3) ? 1'b1 : 1'b0;
      drive(0, 0, 1, 0, 8'h00, b, bv);
      m_q = b; m_v = bv;
      chk("t6_d1_q", {63'h0, q1_out}, {63'h0, m_q});
      chk("t6_d1_valid", {63'h0, q1_valid}, {63'h0, m_v});
      chk("t6_d1_occ", {63'h0, occ1}, {63'h0, m_v});
      chk("t6_d1_tap", {63'h0, tap1}, {63'h0, m_q});
    end
    drive(0, 0, 0, 0, 8'h00, 1, 1);
    chk("t6_d1_hold", {62'h0, q1_valid, q1_out}, {62'h0, m_v, m_q});

    ntotal++;
    if (exp_q.size() == 0) npass++;
    else $display("FAIL sb_leftover: got %0d pending entries expected 0", exp_q.size());

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
